pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard controller for the in-order pipeline. Each cycle it sets per-latch write-enable
//  and flush vectors and the PC update controls. Handles d-cache miss freeze, load-use interlock,
//  i-cache miss bubbles, jump and taken-branch flushes, and redirects that arrive during an i-miss
//  (held pending until the fetch completes). Also handles sticky halt and saturating stall/flush counters.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the in-order pipeline: per-latch write enables and flushes,
// PC update controls, sticky halt and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int NLAT    = 4,
    parameter int JMP_LAT = 0,
    parameter int BR_LAT  = 1,
    parameter int MEM_LAT = 2,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_memread,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic             jmp_taken,
    input  logic             br_taken,
    input  logic             wb_halt,
    output logic [NLAT-1:0]  latW,
    output logic [NLAT-1:0]  latFlush,
    output logic             pc_W,
    output logic [1:0]       pc_src,
    output logic             tgt_cap,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_st,
    output logic             dbg_pend
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t st, st_nx;
    logic   pend, pend_nx;
    logic   flush_ev;
    logic   dmiss, loaduse, redir;
    int     span;

    assign dmiss   = (mem_dREN | mem_dWEN) & ~dhit;
    assign loaduse = ex_memread & (ex_rd != '0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign redir   = jmp_taken | br_taken;
    assign span    = br_taken ? BR_LAT : JMP_LAT;

    assign dbg_st   = st;
    assign dbg_pend = pend;

    always_comb begin
        latW     = '1;
        latFlush = '0;
        pc_W     = 1'b1;
        pc_src   = 2'b00;
        tgt_cap  = 1'b0;
        halted   = 1'b0;
        flush_ev = 1'b0;
        st_nx    = st;
        pend_nx  = pend;
        if (!nRST) begin
            latW     = '0;
            latFlush = '1;
            pc_W     = 1'b0;
            st_nx    = RUN;
            pend_nx  = 1'b0;
        end else if (st == HALT || wb_halt) begin
            latW   = '0;
            pc_W   = 1'b0;
            halted = 1'b1;
            st_nx  = HALT;
        end else if (dmiss) begin
            // Freeze everything up to MEM; the stage past MEM drains as a bubble.
            for (int i = 0; i < NLAT; i++) begin
                if (i <= MEM_LAT) latW[i] = 1'b0;
                else              latFlush[i] = 1'b1;
            end
            pc_W  = 1'b0;
            st_nx = DWAIT;
        end else begin
            st_nx = RUN;
            if (redir) begin
                for (int i = 0; i < NLAT; i++) begin
                    if (i <= span) latFlush[i] = 1'b1;
                end
                flush_ev = 1'b1;
                if (ihit) begin
                    pc_src  = 2'b01;
                    pend_nx = 1'b0;
                end else begin
                    pc_W    = 1'b0;
                    tgt_cap = 1'b1;
                    pend_nx = 1'b1;
                end
            end else if (loaduse) begin
                latW[0]     = 1'b0;
                latFlush[1] = 1'b1;
                pc_W        = 1'b0;
            end else if (pend && ihit) begin
                // Word fetched during the miss is wrong-path; drop it and take the held target.
                pc_src      = 2'b10;
                latFlush[0] = 1'b1;
                pend_nx     = 1'b0;
            end else if (!ihit) begin
                pc_W        = 1'b0;
                latFlush[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            st        <= RUN;
            pend      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            st   <= st_nx;
            pend <= pend_nx;
            if (!pc_W && st != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_ev && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vectors, a rule-level reference model
// checked every cycle, and hand-computed literal checks.
module tb_pipeline_hazard_ctrl;

    localparam int NLAT = 4, JMP_LAT = 0, BR_LAT = 1, MEM_LAT = 2, RA_W = 5, CNT_W = 4;
    localparam int CMAX = 15;

    logic CLK = 1'b0;
    logic nRST, ihit, dhit, mem_dREN, mem_dWEN, ex_memread, id_uses_rt;
    logic jmp_taken, br_taken, wb_halt;
    logic [RA_W-1:0] ex_rd, id_rs, id_rt;
    logic [NLAT-1:0] latW, latFlush;
    logic pc_W, tgt_cap, halted, dbg_pend;
    logic [1:0] pc_src, dbg_st;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(
        .NLAT(NLAT), .JMP_LAT(JMP_LAT), .BR_LAT(BR_LAT), .MEM_LAT(MEM_LAT),
        .RA_W(RA_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .jmp_taken(jmp_taken), .br_taken(br_taken),
        .wb_halt(wb_halt), .latW(latW), .latFlush(latFlush), .pc_W(pc_W),
        .pc_src(pc_src), .tgt_cap(tgt_cap), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_st(dbg_st), .dbg_pend(dbg_pend)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: outputs derived from the hazard rules each cycle
    bit m_halt = 0, m_pend = 0;
    int m_stall = 0, m_flush = 0;
    logic [3:0] e_w, e_f;
    logic [1:0] e_src;
    logic e_pw, e_cap, e_halt, e_ev;

    function automatic logic [3:0] low_mask(input int k);
        logic [3:0] m;
        m = 4'((1 << (k + 1)) - 1);
        return m;
    endfunction

    always @(negedge CLK) begin
        bit dm, lu, rd;
        dm = (mem_dREN || mem_dWEN) && !dhit;
        lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        rd = jmp_taken || br_taken;
        e_w = 4'hF; e_f = 4'h0; e_pw = 1; e_src = 0; e_cap = 0; e_halt = 0; e_ev = 0;
        if (!nRST) begin
            e_w = 0; e_f = 4'hF; e_pw = 0;
        end else if (m_halt || wb_halt) begin
            e_w = 0; e_pw = 0; e_halt = 1;
        end else if (dm) begin
            e_w = ~low_mask(MEM_LAT); e_f = ~low_mask(MEM_LAT); e_pw = 0;
        end else if (rd) begin
            e_f = low_mask(br_taken ? BR_LAT : JMP_LAT);
            e_ev = 1; e_pw = ihit; e_src = ihit ? 2'b01 : 2'b00; e_cap = !ihit;
        end else if (lu) begin
            e_w = 4'b1110; e_f = 4'b0010; e_pw = 0;
        end else if (m_pend && ihit) begin
            e_src = 2'b10; e_f = 4'b0001;
        end else if (!ihit) begin
            e_pw = 0; e_f = 4'b0001;
        end
        chk("m_latW", latW, e_w);
        chk("m_latFlush", latFlush, e_f);
        chk("m_pc_W", pc_W, e_pw);
        chk("m_pc_src", pc_src, e_src);
        chk("m_tgt_cap", tgt_cap, e_cap);
        chk("m_halted", halted, e_halt);
        chk("m_pend", dbg_pend, m_pend);
        chk("m_stall_cnt", stall_cnt, m_stall);
        chk("m_flush_cnt", flush_cnt, m_flush);
        if (!nRST) begin
            m_halt = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pw && !m_halt) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
            if (e_ev) begin
                m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
                m_pend = !ihit;
            end else if (!m_halt && !wb_halt && !dm && !lu && m_pend && ihit) begin
                m_pend = 0;
            end
            if (e_halt) m_halt = 1;
        end
    end

    // driver tasks
    task automatic idle();
        nRST = 1; ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
        ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        jmp_taken = 0; br_taken = 0; wb_halt = 0;
    endtask

    task automatic settle();
        @(negedge CLK); #1;
    endtask

    task automatic next();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(input int n);
        idle(); nRST = 0;
        for (int i = 0; i < n; i++) begin
            settle();
            chk("rst_latW", latW, 4'h0);
            chk("rst_latFlush", latFlush, 4'hF);
            next();
        end
        idle();
    endtask

    initial begin
        // 1: reset then steady fetch
        do_reset(3);
        settle();
        chk("run_latW", latW, 4'hF);
        chk("run_latFlush", latFlush, 4'h0);
        chk("run_pc_W", pc_W, 1);
        chk("run_pc_src", pc_src, 0);
        chk("run_stall", stall_cnt, 0);
        chk("run_flush", flush_cnt, 0);
        next();

        // 2: d-cache miss freeze
        mem_dREN = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("dm_latW", latW, 4'b1000);
            chk("dm_latFlush", latFlush, 4'b1000);
            chk("dm_pc_W", pc_W, 0);
            next();
        end
        dhit = 1;
        settle(); chk("dm_stall3", stall_cnt, 3); chk("dm_done_latW", latW, 4'hF); next();
        idle(); mem_dWEN = 1;
        settle(); chk("dmw_latW", latW, 4'b1000); next();
        idle();

        // 3: load-use interlock
        ex_memread = 1; ex_rd = 5; id_rs = 5;
        settle();
        chk("lu_latW", latW, 4'b1110);
        chk("lu_latFlush", latFlush, 4'b0010);
        chk("lu_pc_W", pc_W, 0);
        next();
        ex_rd = 0; id_rs = 0;
        settle(); chk("lu_r0_pc_W", pc_W, 1); chk("lu_r0_latW", latW, 4'hF); next();
        ex_rd = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1;
        settle(); chk("lu_rt_pc_W", pc_W, 0); next();
        id_uses_rt = 0;
        settle(); chk("lu_nort_pc_W", pc_W, 1); next();
        ex_rd = 7; id_rs = 7; ihit = 0;
        settle(); chk("lu_noihit_latFlush", latFlush, 4'b0010); chk("lu_noihit_latW", latW, 4'b1110); next();
        idle();

        // 4: taken branch / jump with fetch complete
        br_taken = 1;
        settle(); chk("br_latFlush", latFlush, 4'b0011); chk("br_pc_src", pc_src, 1); next();
        idle();
        settle(); chk("br_flush_cnt", flush_cnt, 1); next();
        jmp_taken = 1;
        settle(); chk("jmp_latFlush", latFlush, 4'b0001); next();
        idle();
        settle(); chk("jmp_flush_cnt", flush_cnt, 2); next();

        // 5: jump during i-miss, held target
        jmp_taken = 1; ihit = 0;
        settle(); chk("pj_tgt_cap", tgt_cap, 1); chk("pj_pc_W0", pc_W, 0); next();
        jmp_taken = 0;
        settle(); chk("pj_pc_W1", pc_W, 0); chk("pj_pend", dbg_pend, 1); next();
        ihit = 1;
        settle(); chk("pj_pc_src", pc_src, 2'b10); chk("pj_latFlush", latFlush, 4'b0001); next();
        settle(); chk("pj_pend_clr", dbg_pend, 0); chk("pj_flush_cnt", flush_cnt, 3); next();

        // redirect deferred by d-miss counts once; second redirect while pending
        br_taken = 1; mem_dREN = 1;
        settle(); chk("brdm_latFlush", latFlush, 4'b1000); next();
        dhit = 1;
        settle(); chk("brdm_latFlush2", latFlush, 4'b0011); next();
        idle();
        settle(); chk("brdm_flush_cnt", flush_cnt, 4); next();
        jmp_taken = 1; ihit = 0; next();
        jmp_taken = 0; br_taken = 1;
        settle(); chk("re_tgt_cap", tgt_cap, 1); next();
        idle(); mem_dREN = 1; ihit = 0; next();
        idle(); ex_memread = 1; ex_rd = 4; id_rs = 4; ihit = 1;
        settle(); chk("re_pend_held", dbg_pend, 1); next();
        idle(); next();

        // 6: sticky halt, cleared only by reset
        wb_halt = 1;
        settle(); chk("h_halted", halted, 1); chk("h_latW", latW, 0); next();
        idle(); ihit = 0; br_taken = 1; mem_dREN = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("h_hold_halted", halted, 1);
            chk("h_hold_pc_W", pc_W, 0);
            next();
            ihit = ~ihit; br_taken = ~br_taken;
        end
        do_reset(1);
        settle();
        chk("h_rst_halted", halted, 0);
        chk("h_rst_stall", stall_cnt, 0);
        chk("h_rst_flush", flush_cnt, 0);
        next();

        // saturation of both counters
        ihit = 0;
        repeat (20) next();
        idle();
        settle(); chk("sat_stall", stall_cnt, CMAX); next();
        br_taken = 1;
        repeat (18) next();
        idle();
        settle(); chk("sat_flush", flush_cnt, CMAX); next();
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
